lcd_hd44780_tx: RTL and testbench

Write-only HD44780 character-LCD transmitter. It sits behind the LCD output peripheral of the pipelined RISC-V core and turns byte-level command and data writes (valid/ready) into HD44780 parallel-bus cycles with fixed timing. After reset it runs the power-up initialisation sequence on its own. Waits are timed; the busy flag is never read.

---
 rtl/lcd_hd44780_tx.sv | 159 +++++++++++++++
 tb/tb_lcd_hd44780_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_tx.sv
// Write-only HD44780 bus transmitter: runs the power-up init sequence after reset,
// then turns valid/ready byte writes into timed E-strobe cycles (busy flag never read).
module lcd_hd44780_tx #(
    parameter int T_POWERUP    = 750000,
    parameter int T_SETUP      = 4,
    parameter int T_EN_HIGH    = 12,
    parameter int T_HOLD       = 4,
    parameter int T_CMD_WAIT   = 2000,
    parameter int T_CLEAR_WAIT = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_init_done,
    output logic       o_busy
);

    localparam int T_MAX_A = (T_POWERUP > T_CLEAR_WAIT) ? T_POWERUP : T_CLEAR_WAIT;
    localparam int T_MAX_B = (T_CMD_WAIT > T_EN_HIGH) ? T_CMD_WAIT : T_EN_HIGH;
    localparam int T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
    localparam int CW      = ($clog2(T_MAX + 1) > 20) ? $clog2(T_MAX + 1) : 20;

    localparam logic [CW-1:0] PWR_LAST = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(T_CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(T_CLEAR_WAIT - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_long;
    logic          w_last;

    // {long_wait, byte}; the three wake-up 0x30s collapse into entries 0 and 1
    function automatic logic [8:0] rom(input logic [2:0] idx);
        case (idx)
            3'd0:    rom = {1'b1, 8'h30};
            3'd1:    rom = {1'b0, 8'h30};
            3'd2:    rom = {1'b0, 8'h38};
            3'd3:    rom = {1'b0, 8'h08};
            3'd4:    rom = {1'b1, 8'h01};
            3'd5:    rom = {1'b0, 8'h06};
            3'd6:    rom = {1'b0, 8'h0C};
            default: rom = {1'b0, 8'h00};
        endcase
    endfunction

    assign w_last   = (r_cnt == '0);
    assign o_lcd_rw = 1'b0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_PWRUP;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_long      <= 1'b0;
            o_ready     <= 1'b0;
            o_busy      <= 1'b1;
            o_init_done <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_data  <= 8'h00;
            o_lcd_rs    <= 1'b0;
            o_lcd_on    <= 1'b0;
        end else begin
            o_lcd_on <= 1'b1;
            case (r_state)
                // counts up from the reset value of 0 so PWRUP lasts exactly T_POWERUP
                S_PWRUP: begin
                    if (r_cnt == PWR_LAST) begin
                        {r_long, o_lcd_data} <= rom(3'd0);
                        o_lcd_rs <= 1'b0;
                        r_idx    <= 3'd0;
                        r_cnt    <= SETUP_LD;
                        r_state  <= S_SETUP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SETUP: begin
                    if (w_last) begin
                        o_lcd_en <= 1'b1;
                        r_cnt    <= EN_LD;
                        r_state  <= S_EN_HI;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_EN_HI: begin
                    if (w_last) begin
                        o_lcd_en <= 1'b0;
                        r_cnt    <= HOLD_LD;
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_last) begin
                        r_cnt   <= r_long ? CLR_LD : CMD_LD;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (w_last) begin
                        if (!o_init_done && r_idx != 3'd6) begin
                            r_idx                <= r_idx + 3'd1;
                            {r_long, o_lcd_data} <= rom(r_idx + 3'd1);
                            o_lcd_rs             <= 1'b0;
                            r_cnt                <= SETUP_LD;
                            r_state              <= S_SETUP;
                        end else begin
                            o_init_done <= 1'b1;
                            o_ready     <= 1'b1;
                            o_busy      <= 1'b0;
                            r_cnt       <= '0;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_IDLE: begin
                    if (i_valid) begin
                        o_lcd_data <= i_data;
                        o_lcd_rs   <= i_rs;
                        r_long     <= !i_rs && (i_data == 8'h01 || i_data == 8'h02);
                        o_ready    <= 1'b0;
                        o_busy     <= 1'b1;
                        r_cnt      <= SETUP_LD;
                        r_state    <= S_SETUP;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_tx.sv
// Randomized bench for lcd_hd44780_tx: a timeline model predicts accept edges,
// ready/busy/init_done per cycle, and every E pulse's byte, RS, rise edge and width.
module tb_lcd_hd44780_tx;

    localparam int T_POWERUP    = 10;
    localparam int T_SETUP      = 2;
    localparam int T_EN_HIGH    = 3;
    localparam int T_HOLD       = 1;
    localparam int T_CMD_WAIT   = 5;
    localparam int T_CLEAR_WAIT = 20;
    localparam int T_XFER       = T_SETUP + T_EN_HIGH + T_HOLD;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic       o_ready;
    logic       i_rs;
    logic [7:0] i_data;
    logic [7:0] o_lcd_data;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic       o_lcd_en;
    logic       o_lcd_on;
    logic       o_init_done;
    logic       o_busy;

    lcd_hd44780_tx #(
        .T_POWERUP   (T_POWERUP),
        .T_SETUP     (T_SETUP),
        .T_EN_HIGH   (T_EN_HIGH),
        .T_HOLD      (T_HOLD),
        .T_CMD_WAIT  (T_CMD_WAIT),
        .T_CLEAR_WAIT(T_CLEAR_WAIT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs       (i_rs),
        .i_data     (i_data),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_init_done(o_init_done),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         rise;
    } pulse_t;

    pulse_t     q[$];
    logic [7:0] init_seq [7];
    int         cyc;
    int         rdy_edge;
    int         init_edge;
    int         n_chk;
    int         n_fail;

    // cyc = number of edges since reset release; sampled at negedges
    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wait_len(input logic rs, input logic [7:0] d, input logic first);
        return (first || (!rs && (d == 8'h01 || d == 8'h02))) ? T_CLEAR_WAIT : T_CMD_WAIT;
    endfunction

    task automatic init_model();
        int     l;
        pulse_t p;
        l = T_POWERUP;
        for (int i = 0; i < 7; i++) begin
            p.d = init_seq[i]; p.rs = 1'b0; p.rise = l + T_SETUP;
            q.push_back(p);
            l += T_XFER + wait_len(1'b0, init_seq[i], i == 0);
        end
        init_edge = l;
        rdy_edge  = l;
    endtask

    task automatic chk_reset();
        chk("rst_ready",     32'(o_ready),     32'd0);
        chk("rst_busy",      32'(o_busy),      32'd1);
        chk("rst_init_done", 32'(o_init_done), 32'd0);
        chk("rst_en",        32'(o_lcd_en),    32'd0);
        chk("rst_data",      32'(o_lcd_data),  32'd0);
        chk("rst_rs",        32'(o_lcd_rs),    32'd0);
        chk("rst_rw",        32'(o_lcd_rw),    32'd0);
        chk("rst_on",        32'(o_lcd_on),    32'd0);
    endtask

    task automatic mchk();
        chk("ready",     32'(o_ready),     32'(cyc >= rdy_edge));
        chk("busy",      32'(o_busy),      32'(cyc < rdy_edge));
        chk("init_done", 32'(o_init_done), 32'(cyc >= init_edge));
        chk("lcd_on",    32'(o_lcd_on),    32'd1);
    endtask

    task automatic spin(input int n, input logic v, input logic [7:0] d);
        i_valid = v; i_rs = 1'b1; i_data = d;
        repeat (n) begin
            @(negedge i_clk);
            mchk();
        end
    endtask

    // Presents a request and returns at the negedge after the accept edge with i_valid still high
    task automatic send(input logic rs, input logic [7:0] d);
        int     c, acc, n;
        pulse_t p;
        i_valid = 1'b1; i_rs = rs; i_data = d;
        c = cyc; n = 0;
        mchk();
        while (!o_ready && n < 300) begin
            @(negedge i_clk);
            mchk();
            n++;
        end
        if (!o_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            return;
        end
        acc = cyc + 1;
        chk("accept_edge", 32'(acc), 32'(((c > rdy_edge) ? c : rdy_edge) + 1));
        p.d = d; p.rs = rs; p.rise = acc + T_SETUP;
        q.push_back(p);
        rdy_edge = acc + T_XFER + wait_len(rs, d, 1'b0);
        @(negedge i_clk);
        chk("lcd_data", 32'(o_lcd_data), 32'(d));
        chk("lcd_rs",   32'(o_lcd_rs),   32'(rs));
    endtask

    // Pulse monitor: each E rise must match the next expected transfer
    initial begin : mon
        logic   prev;
        int     w;
        pulse_t e;
        prev = 1'b0; w = 0;
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                prev = 1'b0; w = 0;
            end else begin
                if (o_lcd_en && !prev) begin
                    if (q.size() == 0) begin
                        chk("extra_pulse", 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        chk("pulse_data", 32'(o_lcd_data), 32'(e.d));
                        chk("pulse_rs",   32'(o_lcd_rs),   32'(e.rs));
                        chk("pulse_rise", 32'(cyc),        32'(e.rise));
                        chk("pulse_rw",   32'(o_lcd_rw),   32'd0);
                    end
                    w = 0;
                end
                if (o_lcd_en) w++;
                else if (prev) chk("pulse_width", 32'(w), 32'(T_EN_HIGH));
                prev = o_lcd_en;
            end
        end
    end

    initial begin
        init_seq = '{8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        n_chk = 0; n_fail = 0; rdy_edge = 0; init_edge = 0;
        i_reset = 1'b0; i_valid = 1'b0; i_rs = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge i_clk);
        chk_reset();
        i_reset = 1'b1;
        init_model();

        // requests during init (covers the second init E pulse) must be ignored
        spin(30, 1'b0, 8'h00);
        spin(20, 1'b1, 8'h55);
        spin(1, 1'b0, 8'h00);

        send(1'b1, 8'h41);
        spin(1, 1'b0, 8'h00);
        send(1'b0, 8'h01);
        spin(2, 1'b0, 8'h00);
        send(1'b1, 8'h01);
        spin(1, 1'b0, 8'h00);
        send(1'b1, 8'h48);
        send(1'b1, 8'h49);

        // request raised while E is high must not be taken
        spin(1, 1'b0, 8'h00);
        spin(3, 1'b1, 8'h55);
        spin(1, 1'b0, 8'h00);

        for (int k = 0; k < 30; k++) begin
            logic       rs;
            logic [7:0] d;
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
            if ($urandom_range(0, 2) != 0) spin(int'($urandom_range(1, 3)), 1'b0, 8'h00);
            send(rs, d);
        end

        // reset while E is high
        send(1'b1, 8'h5A);
        spin(2, 1'b0, 8'h00);
        chk("en_before_rst", 32'(o_lcd_en), 32'd1);
        #2 i_reset = 1'b0;
        #1 chk("en_async_drop", 32'(o_lcd_en), 32'd0);
        chk_reset();
        repeat (3) @(negedge i_clk);
        chk_reset();
        chk("queue_after_rst", 32'(q.size()), 32'd0);
        i_reset = 1'b1;
        init_model();
        spin(15, 1'b0, 8'h00);
        send(1'b1, 8'h33);
        spin(T_XFER + T_CMD_WAIT + 1, 1'b0, 8'h00);
        chk("pulses_left", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
